// File: rtl/rotate_arbiter_pkg.sv
// Shared types and constants for the round-robin rotate arbiter.
// Holds the FSM encoding, the per-pass step limit and direction codes.
package rotate_arbiter_pkg;

  localparam int DATA_W   = 8;
  localparam int AMT_W    = 5;
  localparam int STEP_MAX = 7;

  localparam logic DIR_D1 = 1'b1;
  localparam logic DIR_D0 = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Largest pass the 3-bit rotator can take from the remaining amount.
  function automatic logic [2:0] step_of(input logic [AMT_W-1:0] rem);
    return (rem >= AMT_W'(STEP_MAX)) ? 3'(STEP_MAX) : rem[2:0];
  endfunction

endpackage

// File: rtl/rotate_arbiter_rot8_core.sv
// Combinational 8-bit rotator, 0..7 positions per evaluation.
// DIR_D1 moves bits toward LSB, DIR_D0 toward MSB.
module rot8_core
  import rotate_arbiter_pkg::*;
(
  input  logic [7:0] a,
  input  logic [2:0] amt,
  input  logic       dir,
  output logic [7:0] y
);

  logic [15:0] dbl;
  logic [15:0] shr;
  logic [15:0] shl;

  assign dbl = {a, a};
  assign shr = dbl >> amt;
  assign shl = dbl << amt;

  always_comb begin
    y = a;
    unique case (dir)
      DIR_D1: y = shr[7:0];
      DIR_D0: y = shl[15:8];
      default: y = a;
    endcase
  end

endmodule

// File: rtl/rotate_arbiter.sv
// Two-requester round-robin front end for a shared 8-bit rotator.
// Long rotations are split into passes of at most 7 positions.
module rotate_arbiter
  import rotate_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic             req1_dir,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] acc;
  logic [AMT_W-1:0]  rem;
  logic              dir_q;
  logic              id_q;
  logic              last_grant;

  logic              gnt;
  logic              take;
  logic [2:0]        step;
  logic [AMT_W-1:0]  rem_nx;
  logic [DATA_W-1:0] rot_y;
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_amt;
  logic              sel_dir;

  assign step     = step_of(rem);
  assign rem_nx   = rem - AMT_W'(step);
  assign sel_data = gnt ? req1_data : req0_data;
  assign sel_amt  = gnt ? req1_amt  : req0_amt;
  assign sel_dir  = gnt ? req1_dir  : req0_dir;

  rot8_core u_rot (
    .a   (acc),
    .amt (step),
    .dir (dir_q),
    .y   (rot_y)
  );

  always_comb begin
    state_nx   = state;
    gnt        = 1'b0;
    take       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // On a tie, the requester not served last goes next.
        if (req0_valid && req1_valid) gnt = ~last_grant;
        else                          gnt = req1_valid;
        req0_ready = req0_valid && !gnt;
        req1_ready = req1_valid && gnt;
        take       = req0_ready || req1_ready;
        if (take)
          state_nx = (sel_amt != '0) ? ST_ROTATE : ST_DONE;
      end
      ST_ROTATE: begin
        if (rem_nx == '0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      acc        <= '0;
      rem        <= '0;
      dir_q      <= 1'b0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (take) begin
        acc        <= sel_data;
        rem        <= sel_amt;
        dir_q      <= sel_dir;
        id_q       <= gnt;
        last_grant <= gnt;
      end else if (state == ST_ROTATE) begin
        acc <= rot_y;
        rem <= rem_nx;
      end
    end
  end

  assign res_valid = (state == ST_DONE);
  assign res_data  = res_valid ? acc : '0;
  assign res_id    = res_valid & id_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: doc/rotate_arbiter.md
Name: rotate_arbiter

Overview:
- Shares a single 8-bit combinational rotator between two requesters using round-robin arbitration.
- Sequences multi-pass rotations for amounts 0..31, up to 7 positions per clock.
- Returns the result on a valid/ready port tagged with the requester ID.
- Sits between the control logic issuing rotate commands and the rotator datapath.

Parameters:
- DATA_W, 8, data width; fixed at 8 because the rotator core is 8-bit.
- AMT_W, 5, command amount width; maximum total rotation is 31.
- STEP_MAX, 7, maximum positions applied per pass (the rotator's 3-bit amount limit).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_data  in  8  requester 0 operand.
- req0_amt  in  5  requester 0 total rotate amount.
- req0_dir  in  1  requester 0 direction.
- req1_valid / req1_ready / req1_data / req1_amt / req1_dir  same widths and meanings, for requester 1.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  rotated result.
- res_id  out  1  ID of the requester that owns res_data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: state=IDLE; res_valid=0, res_data=0, res_id=0; req0_ready=0, req1_ready=0; busy=0; last_grant=1, so requester 0 wins the first tie.
- Rotation per pass, with step s in 0..7 and direction d:
  - d=1: y[i] = a[(i+s) mod 8]. Example: 0x01, s=1 -> 0x80.
  - d=0: y[i] = a[(i-s) mod 8]. Example: 0x01, s=1 -> 0x02.
- State machine: IDLE -> ROTATE -> DONE -> IDLE.
- IDLE:
  - If either valid is high, grant one requester. If both are valid, grant the one that is not last_grant.
  - reqN_ready is combinational and asserted only in IDLE for the granted requester. It is never high for both requesters and never high outside IDLE.
  - On acceptance (valid & ready): latch data into acc, amt into rem, dir and ID; update last_grant.
  - Next state is ROTATE if amt != 0, otherwise DONE.
- ROTATE:
  - Each cycle: step = (rem >= 7) ? 7 : rem[2:0]; acc <= rot(acc, step, dir); rem <= rem - step.
  - When rem - step == 0, go to DONE.
  - Pass count N = ceil(amt/7): amt=7 -> 1 pass, 8 -> 2, 31 -> 5.
- DONE:
  - res_valid=1; res_data=acc; res_id=latched ID.
  - res_data and res_id stay stable while res_valid & !res_ready.
  - On res_ready, go to IDLE and drop res_valid next cycle.
- Latency from accept edge to res_valid high: N+1 cycles (amt=0 -> 1 cycle).
- Throughput: at most one command per N+2 cycles. No new command is accepted in the cycle the result handshakes; acceptance resumes in the next IDLE cycle.
- Requesters hold their command stable while valid & !ready. A requester dropping valid before ready is legal and simply not granted.
- Reset asserted mid-operation: immediate return to reset values. The in-flight command is discarded and no result is produced.
- Width rules: rem is AMT_W bits and never underflows because step <= rem; acc is 8 bits.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=2'd0, ST_ROTATE=2'd1, ST_DONE=2'd2.
  - STEP_MAX=7.
  - Direction constants: DIR_D1=1, DIR_D0=0.
- Sub-module rot8_core: purely combinational 8-bit rotator with a, 3-bit amt, direction and y. Instantiate it once, driven by acc/step/dir.

Test Plan:
- Single op: req0 {0x01, amt=1, dir=1} -> res_data=0x80, res_id=0, res_valid 2 cycles after accept.
- Multi-pass: req1 {0xB4, amt=9, dir=0} (net 1 left) -> 2 ROTATE cycles, res_data=0x69, res_id=1.
- Zero and max amounts:
  - req0 {0xA5, amt=0} -> res_data=0xA5, 1-cycle latency.
  - amt=31 -> 5 passes; dir=1 gives 0xA5 rotated by net 7, i.e. 0x4B.
- Arbitration: both valid continuously from reset -> grants alternate 0,1,0,1. req1_ready and req0_ready are never high together and never high outside IDLE.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_data/res_id stable, busy=1, no ready to either requester; release -> IDLE next cycle.
- Reset mid-ROTATE (amt=20, assert at pass 2) -> outputs zero immediately, no result emitted. The next req0 command completes correctly.
